// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch/countdown timer: state encoding, second range
// and minute-field width helper.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;

  function automatic int min_width(input int min_max);
    return $clog2(min_max + 1);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Cycle prescaler: counts 0..TICK_DIV-1 while enabled and pulses o_tick on the terminal
// value; i_clr zeroes it. Used for the counted second and the alarm blink.
`timescale 1ns/1ps
module timer_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl_core.sv
// Stopwatch/countdown timer core: control FSM, second prescaler and binary MM:SS count.
// Optional expiry alarm blink is built when TIMER_ALARM_EN is defined.
`timescale 1ns/1ps
module timer_ctrl_core
  import timer_pkg::*;
#(
  parameter  int unsigned TICK_DIV = 50_000_000,
  parameter  int unsigned MIN_MAX  = 99,
  localparam int unsigned MIN_W    = min_width(int'(MIN_MAX))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             sec_inc,
  input  logic             min_inc,
  input  logic             mode_down,
  output logic [5:0]       sec,
  output logic [MIN_W-1:0] min,
  output logic             running,
  output logic             setting,
  output logic             done,
  output logic             alarm
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_sec, w_sec_nxt, w_sec_inc1, w_cnt_sec;
  logic [MIN_W-1:0] r_min, w_min_nxt, w_min_inc1, w_cnt_min;
  logic             r_dir, w_dir_nxt;
  logic             r_running, r_setting, r_done;
  logic             w_presc_clr, w_tick, w_zero, w_start_ok, w_cnt_end, w_in_run;

  assign w_zero     = (r_sec == 6'd0) && (r_min == '0);
  assign w_start_ok = start && !(mode_down && w_zero);
  assign w_in_run   = (r_state == ST_RUN);

  assign w_sec_inc1 = (r_sec == SEC_MAX) ? 6'd0 : r_sec + 6'd1;
  assign w_min_inc1 = (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);

  // Value the count takes on a tick, and whether that value is the terminal one.
  assign w_cnt_sec = r_dir ? ((r_sec == 6'd0) ? SEC_MAX : r_sec - 6'd1) : w_sec_inc1;
  assign w_cnt_min = r_dir ? ((r_sec == 6'd0) ? r_min - MIN_W'(1) : r_min)
                           : ((r_sec == SEC_MAX) ? w_min_inc1 : r_min);
  assign w_cnt_end = r_dir ? ((w_cnt_sec == 6'd0) && (w_cnt_min == '0))
                           : ((w_cnt_sec == SEC_MAX) && (w_cnt_min == MIN_TOP));

  timer_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_in_run),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_dir_nxt   = r_dir;
    w_presc_clr = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_sec_nxt   = '0;
      w_min_nxt   = '0;
      w_presc_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_SET: begin
          if (w_start_ok) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = mode_down;
            w_presc_clr = 1'b1;
          end else if (sec_inc || min_inc) begin
            w_state_nxt = ST_SET;
            if (sec_inc) w_sec_nxt = w_sec_inc1;
            if (min_inc) w_min_nxt = w_min_inc1;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            w_sec_nxt = w_cnt_sec;
            w_min_nxt = w_cnt_min;
            if (w_cnt_end) w_state_nxt = ST_DONE;
          end
          if (stop && !(w_tick && w_cnt_end)) w_state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (start) w_state_nxt = ST_RUN;
        ST_DONE:  ;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sec     <= '0;
      r_min     <= '0;
      r_dir     <= 1'b0;
      r_running <= 1'b0;
      r_setting <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec     <= w_sec_nxt;
      r_min     <= w_min_nxt;
      r_dir     <= w_dir_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_setting <= (w_state_nxt == ST_SET);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign running = r_running;
  assign setting = r_setting;
  assign done    = r_done;

`ifdef TIMER_ALARM_EN
  logic w_in_done, w_not_done, w_blink_tick, r_alarm;

  assign w_in_done  = (r_state == ST_DONE);
  assign w_not_done = !w_in_done;

  timer_prescaler #(.TICK_DIV(TICK_DIV)) u_blink (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_in_done),
    .i_clr  (w_not_done),
    .o_tick (w_blink_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (clear) begin
      r_alarm <= 1'b0;
    end else if ((w_state_nxt == ST_DONE) && !w_in_done) begin
      r_alarm <= 1'b1;
    end else if (w_in_done && w_blink_tick) begin
      r_alarm <= !r_alarm;
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule
